// File: rtl/iosys_pkg.sv
// rtl/iosys_pkg.sv - register map, bit positions and sizing helpers for cheat_regbank
package iosys_pkg;

    localparam logic [31:0] CHEAT_BASE_ADDR    = 32'h0200_0070;
    localparam int          CHEAT_NUM_CODES    = 32;
    localparam int          CHEAT_CODE_WORDS   = 4;
    localparam logic [31:0] CHEAT_WINDOW_BYTES = 32'h0000_0014;

    // word index of each register inside the window (byte offset >> 2)
    typedef enum logic [2:0] {
        REG_CTRL   = 3'd0,
        REG_COUNT  = 3'd1,
        REG_PTR    = 3'd2,
        REG_DATA   = 3'd3,
        REG_STATUS = 3'd4
    } cheat_reg_e;

    // CTRL write bits
    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_COMMIT_BIT  = 1;
    localparam int CTRL_CLEAR_BIT   = 2;
    // CTRL read bits
    localparam int CTRL_PENDING_BIT = 2;
    // STATUS read bits
    localparam int STATUS_PENDING_BIT = 0;
    localparam int STATUS_EN_BIT      = 1;

    function automatic int cheat_depth(input int num_codes, input int code_words);
        return num_codes * code_words;
    endfunction

    function automatic int cheat_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Byte-lane merge of a write into the current register value
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/cheat_regbank.sv
// rtl/cheat_regbank.sv - shadow/active cheat table with vsync commit; CHEAT_READBACK_EN adds DATA readback
module cheat_regbank
    import iosys_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = CHEAT_BASE_ADDR,
    parameter int          NUM_CODES       = CHEAT_NUM_CODES,
    parameter int          CODE_WORDS      = CHEAT_CODE_WORDS,
    parameter bit          COMMIT_ON_VSYNC = 1'b1
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              mem_valid,
    input  logic [31:0]                       mem_addr,
    input  logic [31:0]                       mem_wdata,
    input  logic [3:0]                        mem_wstrb,
    output logic                              sel,
    output logic                              mem_ready,
    output logic [31:0]                       mem_rdata,
    input  logic                              vsync,
    output logic                              o_cheats_enabled,
    output logic                              o_cheats_available,
    output logic [7:0]                        o_cheats_loaded,
    output logic [NUM_CODES*CODE_WORDS*32-1:0] o_cheats_data
);

    localparam int DEPTH = cheat_depth(NUM_CODES, CODE_WORDS);
    localparam int PTR_W = cheat_ptr_w(DEPTH);

    logic [31:0]      shadow [DEPTH];
    logic [31:0]      active [DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [7:0]       shadow_count;
    logic             shadow_en;
    logic [7:0]       active_count;
    logic             active_en;
    logic             pending;
    logic             vsync_d;

    logic [31:0] offset;
    logic        access;
    logic        wr;
    logic        aligned;
    cheat_reg_e  reg_idx;
    logic        wr_ctrl;
    logic        wr_count;
    logic        wr_ptr;
    logic        wr_data;
    logic [31:0] ptr_merged;
    logic        ptr_ok;
    logic [31:0] count_merged;
    logic [7:0]  count_next;
    logic [PTR_W-1:0] ptr_inc;
    logic        trigger;
    logic        commit;
    logic [31:0] rd_mux;

    // Address decode: word-aligned registers inside the window; unaligned offsets are acked but inert
    assign offset   = mem_addr - BASE_ADDR;
    assign sel      = mem_valid & (offset < CHEAT_WINDOW_BYTES);
    assign access   = sel & mem_ready;
    assign wr       = access & (mem_wstrb != 4'b0000);
    assign aligned  = (offset[1:0] == 2'b00);
    assign reg_idx  = cheat_reg_e'(offset[4:2]);
    assign wr_ctrl  = wr & aligned & (reg_idx == REG_CTRL) & mem_wstrb[0];
    assign wr_count = wr & aligned & (reg_idx == REG_COUNT);
    assign wr_ptr   = wr & aligned & (reg_idx == REG_PTR);
    assign wr_data  = wr & aligned & (reg_idx == REG_DATA);

    assign ptr_merged   = merge_lanes(32'(ptr), mem_wdata, mem_wstrb);
    assign ptr_ok       = ptr_merged < 32'(DEPTH);
    assign count_merged = merge_lanes({24'b0, shadow_count}, mem_wdata, mem_wstrb);
    assign count_next   = (count_merged > 32'(NUM_CODES)) ? 8'(NUM_CODES) : count_merged[7:0];
    assign ptr_inc      = (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;

    assign trigger = COMMIT_ON_VSYNC ? (vsync & ~vsync_d) : 1'b1;
    assign commit  = pending & trigger;

    // One-cycle ack pulse per access; the access takes effect on the ack edge
    always_ff @(posedge clk) begin
        if (!resetn) mem_ready <= 1'b0;
        else         mem_ready <= sel & ~mem_ready;
    end

    // Previous vsync level for rising-edge detection
    always_ff @(posedge clk) begin
        if (!resetn) vsync_d <= 1'b0;
        else         vsync_d <= vsync;
    end

    // Shadow side: firmware-visible table, count, enable and auto-incrementing pointer
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) shadow[i] <= '0;
            ptr          <= '0;
            shadow_count <= '0;
            shadow_en    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                shadow_en <= mem_wdata[CTRL_EN_BIT];
                if (mem_wdata[CTRL_CLEAR_BIT]) begin
                    for (int i = 0; i < DEPTH; i++) shadow[i] <= '0;
                    shadow_count <= '0;
                    ptr          <= '0;
                end
            end
            if (wr_count) shadow_count <= count_next;
            if (wr_ptr && ptr_ok) ptr <= ptr_merged[PTR_W-1:0];
            if (wr_data) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wstrb[b]) shadow[ptr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
                ptr <= ptr_inc;
            end
        end
    end

    // Active side: atomic copy on commit; a request on the commit edge re-arms pending,
    // and a disable write overrides the enable copied by a simultaneous commit
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) active[i] <= '0;
            active_count <= '0;
            active_en    <= 1'b0;
            pending      <= 1'b0;
        end else begin
            if (commit) begin
                for (int i = 0; i < DEPTH; i++) active[i] <= shadow[i];
                active_count <= shadow_count;
                active_en    <= shadow_en;
                pending      <= 1'b0;
            end
            if (wr_ctrl) begin
                if (mem_wdata[CTRL_COMMIT_BIT]) pending   <= 1'b1;
                if (!mem_wdata[CTRL_EN_BIT])    active_en <= 1'b0;
            end
        end
    end

    // Register read mux
    always_comb begin
        rd_mux = '0;
        if (aligned) begin
            case (reg_idx)
                REG_CTRL: begin
                    rd_mux[CTRL_PENDING_BIT] = pending;
                    rd_mux[CTRL_EN_BIT]      = shadow_en;
                end
                REG_COUNT: rd_mux = {24'b0, shadow_count};
                REG_PTR:   rd_mux = 32'(ptr);
`ifdef CHEAT_READBACK_EN
                REG_DATA:  rd_mux = shadow[ptr];
`endif
                REG_STATUS: begin
                    rd_mux = {16'(NUM_CODES), active_count, 8'h00};
                    rd_mux[STATUS_EN_BIT]      = active_en;
                    rd_mux[STATUS_PENDING_BIT] = pending;
                end
                default: rd_mux = '0;
            endcase
        end
    end

    assign mem_rdata = mem_ready ? rd_mux : 32'h0;

    assign o_cheats_enabled   = active_en;
    assign o_cheats_available = active_en & (active_count != 8'd0);
    assign o_cheats_loaded    = active_count;

    for (genvar g = 0; g < DEPTH; g++) begin : g_out
        assign o_cheats_data[32*g +: 32] = active[g];
    end

endmodule
